// File: rtl/c7bifu_fetch.sv
// Instruction fetch sequencer: single-outstanding 64-bit bus reads feeding a
// one-entry output register, with realignment for 4-byte-offset redirect targets.
module c7bifu_fetch #(
  parameter logic [31:0] RESET_PC = 32'h1C00_0000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        flush,
  input  logic [31:0] flush_pc,
  input  logic        iq_full,
  output logic        req_vld,
  output logic [31:0] req_addr,
  input  logic        req_rdy,
  input  logic        rsp_vld,
  input  logic [63:0] rsp_data,
  output logic        data_vld,
  output logic [31:0] data_addr,
  output logic [63:0] data
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DROP} state_t;

  state_t       state;
  logic [31:3]  fetch_pc;
  logic         mis;
  logic         prime;
  logic [31:0]  hold;

  logic         accept;
  logic         slot_ok;
  logic [31:0]  blk;
  logic         unused_flush_lsb;

  assign accept           = data_vld & ~iq_full;
  assign slot_ok          = ~data_vld | accept;
  assign blk              = {fetch_pc, 3'b000};
  assign unused_flush_lsb = ^flush_pc[1:0];

  // Merge the upper word of the previous block with the lower word of this one.
  function automatic logic [63:0] realign(input logic [31:0] lo_word,
                                          input logic [31:0] prev_hi);
    return {lo_word, prev_hi};
  endfunction

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= IDLE;
      fetch_pc  <= RESET_PC[31:3];
      mis       <= RESET_PC[2];
      prime     <= RESET_PC[2];
      hold      <= 32'd0;
      req_vld   <= 1'b0;
      req_addr  <= 32'd0;
      data_vld  <= 1'b0;
      data_addr <= 32'd0;
      data      <= 64'd0;
    end else if (flush) begin
      fetch_pc <= flush_pc[31:3];
      mis      <= flush_pc[2];
      prime    <= flush_pc[2];
      data_vld <= 1'b0;
      req_vld  <= 1'b0;
      // A request already on the bus still owes us a response: swallow it.
      if ((state == WAIT && !rsp_vld) || (state == REQ && req_rdy) ||
          (state == DROP && !rsp_vld))
        state <= DROP;
      else
        state <= IDLE;
    end else begin
      if (accept)
        data_vld <= 1'b0;
      case (state)
        IDLE: begin
          if (slot_ok) begin
            req_vld  <= 1'b1;
            req_addr <= blk;
            state    <= REQ;
          end
        end
        REQ: begin
          if (req_rdy) begin
            req_vld <= 1'b0;
            state   <= WAIT;
          end
        end
        WAIT: begin
          if (rsp_vld) begin
            state    <= IDLE;
            fetch_pc <= fetch_pc + 29'd1;
            if (!mis) begin
              data_vld  <= 1'b1;
              data      <= rsp_data;
              data_addr <= blk;
            end else if (prime) begin
              hold  <= rsp_data[63:32];
              prime <= 1'b0;
            end else begin
              data_vld  <= 1'b1;
              data      <= realign(rsp_data[31:0], hold);
              data_addr <= blk - 32'd4;
              hold      <= rsp_data[63:32];
            end
          end
        end
        DROP: begin
          if (rsp_vld)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
